// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Turns level changes on N debounced button inputs into one-deep pending
//   events per channel and presents them one at a time on a valid/ready port,
//   granting channels round-robin.
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   synchronous active-high reset
//   level        in   [N-1:0] debounced levels, synchronous to clk
//   enable       in   1 = detect new edges, 0 = ignore edges (pending still drains)
//   evt_valid    out  event presented
//   evt_ready    in   consumer accepts when evt_valid & evt_ready
//   evt_id       out  [ID_W-1:0] channel index of the presented event
//   evt_rise     out  1 = rising edge, 0 = falling edge
//   overrun      out  [N-1:0] sticky, an edge was dropped on that channel
//   clr_overrun  in   clears all overrun bits (a same-cycle set wins)
module edge_event_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    level,
  input  logic            enable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic            evt_rise,
  output logic [N-1:0]    overrun,
  input  logic            clr_overrun
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_prev;
  logic [N-1:0]    r_pend;
  logic [N-1:0]    r_pend_dir;
  logic [N-1:0]    r_overrun;
  logic [ID_W-1:0] r_rr_ptr;
  logic            r_evt_valid;
  logic [ID_W-1:0] r_evt_id;
  logic            r_evt_rise;

  logic [N-1:0]    w_edge;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_load;
  logic [N-1:0]    w_pend_nxt;
  logic [N-1:0]    w_dir_nxt;
  logic [N-1:0]    w_ovr_set;
  logic            w_found;
  logic [ID_W-1:0] w_gnt_idx;
  logic            w_gnt_dir;
  logic            w_grant;
  logic [ID_W-1:0] w_rr_nxt;
  int unsigned     w_rr;
  int unsigned     w_dist;
  int unsigned     w_best;

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_rise  = r_evt_rise;
  assign overrun   = r_overrun;

  assign w_edge = {N{enable}} & (level ^ r_prev);

  // Round-robin pick: the pending channel with the smallest distance from
  // rr_ptr, distance taken modulo N with an explicit wrap.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_gnt_dir = 1'b0;
    w_rr      = 32'(r_rr_ptr);
    w_dist    = 0;
    w_best    = N;
    for (int unsigned j = 0; j < N; j++) begin
      w_dist = (j >= w_rr) ? (j - w_rr) : (j + N - w_rr);
      if (r_pend[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(j);
        w_gnt_dir = r_pend_dir[j];
      end
    end
  end

  // A grant happens from IDLE, or from PRESENT when the current event is taken.
  assign w_grant  = w_found && ((r_state == S_IDLE) || evt_ready);
  assign w_rr_nxt = (w_gnt_idx == ID_W'(N - 1)) ? '0 : (w_gnt_idx + ID_W'(1));

  always_comb begin
    w_clr = '0;
    for (int unsigned j = 0; j < N; j++) begin
      w_clr[j] = w_grant && (w_gnt_idx == ID_W'(j));
    end
  end

  // A new edge loads only into an empty slot or one being granted this cycle;
  // otherwise the older event is kept and the drop is flagged.
  assign w_load     = w_edge & (~r_pend | w_clr);
  assign w_pend_nxt = (r_pend & ~w_clr) | w_load;
  assign w_dir_nxt  = (r_pend_dir & ~w_load) | (level & w_load);
  assign w_ovr_set  = w_edge & r_pend & ~w_clr;

  // Edge history, pending slots, overrun flags and the output FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev      <= level;
      r_pend      <= '0;
      r_pend_dir  <= '0;
      r_overrun   <= '0;
      r_rr_ptr    <= '0;
      r_state     <= S_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_rise  <= 1'b0;
    end else begin
      r_prev     <= level;
      r_pend     <= w_pend_nxt;
      r_pend_dir <= w_dir_nxt;
      r_overrun  <= (clr_overrun ? '0 : r_overrun) | w_ovr_set;
      if (w_grant) begin
        r_rr_ptr <= w_rr_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state     <= S_PRESENT;
            r_evt_valid <= 1'b1;
            r_evt_id    <= w_gnt_idx;
            r_evt_rise  <= w_gnt_dir;
          end
        end
        S_PRESENT: begin
          if (evt_ready) begin
            if (w_grant) begin
              r_evt_id   <= w_gnt_idx;
              r_evt_rise <= w_gnt_dir;
            end else begin
              r_state     <= S_IDLE;
              r_evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
